// File: rtl/mmio_timer_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped timer and the bridge
// that decodes its device slot.
//   - register offsets (device address bits [3:2])
//   - CTRL bit positions and mode encodings
//   - FSM state type
//   - device base constants (address bits [31:4]) shared with the bridge
package mmio_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   localparam logic [27:0] DEV_BASE_0 = 28'h00007F0;
   localparam logic [27:0] DEV_BASE_1 = 28'h00007F1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: register bus between the system bridge and one device slot.
//   addr  [1:0]  register select (device address bits [3:2])
//   we           write strobe, already qualified by the bridge address decode
//   wdata [31:0] write data
//   rdata [31:0] read data returned to the bridge read mux
// Bus semantics: there is no valid/ready pair. A write is accepted on every
// rising clk edge where we=1, unconditionally and with no back-pressure.
// A read has no strobe: rdata continuously reflects the register selected by
// addr, with zero cycles of latency.
interface mmio_timer_if;

   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output we, output wdata, input rdata);
   modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with one-shot and
// auto-reload modes and a maskable interrupt.
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          mmio_timer_if.slave (addr, we, wdata, rdata)
//   irq          interrupt request = pending & CTRL.IM
//   state_dbg    current FSM state (debug visibility)
//   pending_dbg  internal pending flag (debug visibility)
module mmio_timer
   import mmio_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   mmio_timer_if.slave  bus,
   output logic         irq,
   output state_t       state_dbg,
   output logic         pending_dbg
);

   logic [3:0]       ctrl;
   logic [WIDTH-1:0] preset;
   logic [WIDTH-1:0] count;
   state_t           state;
   logic             pending;

   logic ctrl_wr;
   logic preset_wr;
   logic en;
   logic reload_mode;
   logic expire;

   assign ctrl_wr     = bus.we && (bus.addr == ADDR_CTRL);
   assign preset_wr   = bus.we && (bus.addr == ADDR_PRESET);
   assign en          = ctrl[CTRL_EN];
   // Mode 1x is deliberately treated as one-shot.
   assign reload_mode = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
   // The edge that moves CNT -> INT.
   assign expire      = (state == CNT) && en && (count == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         state   <= IDLE;
         pending <= 1'b0;
      end else begin
         if (preset_wr) begin
            preset <= bus.wdata[WIDTH-1:0];
         end

         case (state)
            IDLE: begin
               if (en) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!en) begin
                  state <= IDLE;
               end else if (count == '0) begin
                  state <= INT;
               end else begin
                  count <= count - WIDTH'(1);
               end
            end
            INT: begin
               if (reload_mode) begin
                  state <= LOAD;
               end else begin
                  ctrl[CTRL_EN] <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Placed after the FSM so a CTRL write overrides the one-shot EN clear.
         if (ctrl_wr) begin
            ctrl <= bus.wdata[3:0];
         end

         // Entering INT beats a coincident CTRL write; otherwise a CTRL write
         // clears pending, and reload mode drops it on leaving INT.
         if (expire) begin
            pending <= 1'b1;
         end else if (ctrl_wr) begin
            pending <= 1'b0;
         end else if ((state == INT) && reload_mode) begin
            pending <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         ADDR_CTRL:   bus.rdata[3:0]       = ctrl;
         ADDR_PRESET: bus.rdata[WIDTH-1:0] = preset;
         ADDR_COUNT:  bus.rdata[WIDTH-1:0] = count;
         default:     bus.rdata            = '0;
      endcase
   end

   assign irq         = pending & ctrl[CTRL_IM];
   assign state_dbg   = state;
   assign pending_dbg = pending;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed and randomized checks of mmio_timer against a
// cycle-timeline model derived from the timer's timing rules: with EN
// written at edge t and PRESET=N, COUNT=N-k after edge t+2+k, irq rises
// after edge t+3+N, and auto-reload repeats every N+3 cycles.
module tb_mmio_timer;
   import mmio_pkg::*;

   logic   clk = 1'b0;
   logic   reset_n = 1'b0;
   logic   irq;
   logic   pending_dbg;
   state_t state_dbg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mmio_timer_if bus_if ();

   mmio_timer #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus_if),
      .irq         (irq),
      .state_dbg   (state_dbg),
      .pending_dbg (pending_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Drive one bus cycle, then return 1 time unit after the rising edge.
   task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
      bus_if.we    = w;
      bus_if.addr  = a;
      bus_if.wdata = d;
      @(posedge clk);
      #1;
      bus_if.we    = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, ADDR_CTRL, 32'h0);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      bus_if.addr = a;
      #1;
      v = bus_if.rdata;
   endtask

   // One-shot run; c counts edges after the enabling CTRL write.
   task automatic run_oneshot(input int n, input logic im);
      logic [31:0] v;
      int k;
      step(1'b1, ADDR_PRESET, 32'(n));
      step(1'b1, ADDR_CTRL, {28'h0, im, 3'b001});
      for (int c = 1; c <= n + 5; c++) begin
         idle();
         check($sformatf("os_irq n=%0d c=%0d", n, c), {31'h0, irq},
               {31'h0, (im && (c >= n + 3))});
         if (c >= 2) begin
            k = c - 2;
            rd(ADDR_COUNT, v);
            check($sformatf("os_count n=%0d c=%0d", n, c), v, (k <= n) ? 32'(n - k) : 32'h0);
         end
         if (c == n + 5) begin
            rd(ADDR_CTRL, v);
            check($sformatf("os_ctrl_en_clr n=%0d", n), v, {28'h0, im, 3'b000});
            check($sformatf("os_pending n=%0d", n), {31'h0, pending_dbg}, 32'h1);
         end
      end
      step(1'b1, ADDR_CTRL, 32'h8);
      check("os_irq_after_ctrl_wr", {31'h0, irq}, 32'h0);
      check("os_pending_after_ctrl_wr", {31'h0, pending_dbg}, 32'h0);
   endtask

   task automatic run_reload(input int n, input int periods);
      logic [31:0] v;
      int last;
      logic exp_irq;
      step(1'b1, ADDR_PRESET, 32'(n));
      step(1'b1, ADDR_CTRL, 32'hB);
      last = (n + 3) * periods + 1;
      for (int c = 1; c <= last; c++) begin
         idle();
         exp_irq = (c >= n + 3) && (((c - (n + 3)) % (n + 3)) == 0);
         check($sformatf("rl_irq n=%0d c=%0d", n, c), {31'h0, irq}, {31'h0, exp_irq});
         rd(ADDR_CTRL, v);
         check($sformatf("rl_en n=%0d c=%0d", n, c), {31'h0, v[0]}, 32'h1);
      end
      step(1'b1, ADDR_CTRL, 32'h0);
      repeat (4) idle();
   endtask

   initial begin
      logic [31:0] v;
      bus_if.we    = 1'b0;
      bus_if.addr  = 2'd0;
      bus_if.wdata = 32'h0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle();
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         check($sformatf("reset_rd a=%0d", a), v, 32'h0);
      end
      check("reset_irq", {31'h0, irq}, 32'h0);
      check("reset_state", {30'h0, state_dbg}, {30'h0, IDLE});

      // One-shot with PRESET=5, then PRESET=0 boundary
      run_oneshot(5, 1'b1);
      run_oneshot(0, 1'b1);

      // Auto-reload PRESET=3: pulse every 6 cycles for 5 periods
      run_reload(3, 5);

      // Masked one-shot: pending set, irq never rises
      run_oneshot(2, 1'b0);

      // Disable mid-count: EN cleared at the edge that makes COUNT=7
      step(1'b1, ADDR_PRESET, 32'd10);
      step(1'b1, ADDR_CTRL, 32'h1);
      repeat (4) idle();
      step(1'b1, ADDR_CTRL, 32'h0);
      for (int i = 0; i < 3; i++) begin
         rd(ADDR_COUNT, v);
         check($sformatf("freeze_count i=%0d", i), v, 32'd7);
         idle();
      end
      check("freeze_state", {30'h0, state_dbg}, {30'h0, IDLE});

      // Max PRESET
      step(1'b1, ADDR_PRESET, 32'hFFFF_FFFF);
      step(1'b1, ADDR_CTRL, 32'h1);
      idle();
      idle();
      rd(ADDR_COUNT, v);
      check("max_count_t2", v, 32'hFFFF_FFFF);
      idle();
      rd(ADDR_COUNT, v);
      check("max_count_t3", v, 32'hFFFF_FFFE);
      step(1'b1, ADDR_CTRL, 32'h0);
      idle();
      idle();
      rd(ADDR_COUNT, v);
      check("max_count_frozen", v, 32'hFFFF_FFFD);

      // Writes to COUNT and reserved addresses are ignored
      step(1'b1, ADDR_COUNT, $urandom);
      rd(ADDR_COUNT, v);
      check("count_write_ignored", v, 32'hFFFF_FFFD);
      step(1'b1, 2'd3, $urandom);
      rd(2'd3, v);
      check("addr3_reads_zero", v, 32'h0);
      rd(ADDR_CTRL, v);
      check("addr3_ctrl_unchanged", v, 32'h0);
      rd(ADDR_PRESET, v);
      check("addr3_preset_unchanged", v, 32'hFFFF_FFFF);

      // PRESET write mid-count: current period keeps 4, next uses 2
      step(1'b1, ADDR_PRESET, 32'd4);
      step(1'b1, ADDR_CTRL, 32'hB);
      for (int c = 1; c <= 12; c++) begin
         if (c == 3) step(1'b1, ADDR_PRESET, 32'd2);
         else idle();
         check($sformatf("pmid_irq c=%0d", c), {31'h0, irq}, {31'h0, (c == 7) || (c == 12)});
         if (c == 2) begin
            rd(ADDR_COUNT, v);
            check("pmid_count_old", v, 32'd4);
         end
         if (c == 9) begin
            rd(ADDR_COUNT, v);
            check("pmid_count_new", v, 32'd2);
         end
      end
      step(1'b1, ADDR_CTRL, 32'h0);
      repeat (4) idle();

      // Randomized runs
      repeat (4) run_oneshot(int'($urandom_range(0, 12)), 1'b1);
      repeat (2) run_reload(int'($urandom_range(0, 5)), 3);

      // Reset mid-count takes effect without a clock edge
      step(1'b1, ADDR_PRESET, 32'd20);
      step(1'b1, ADDR_CTRL, 32'h9);
      repeat (4) idle();
      rd(ADDR_COUNT, v);
      check("pre_reset_count", v, 32'd18);
      reset_n = 1'b0;
      rd(ADDR_COUNT, v);
      check("async_reset_count", v, 32'h0);
      check("async_reset_irq", {31'h0, irq}, 32'h0);
      check("async_reset_state", {30'h0, state_dbg}, {30'h0, IDLE});
      rd(ADDR_CTRL, v);
      check("async_reset_ctrl", v, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) idle();
      check("post_reset_state", {30'h0, state_dbg}, {30'h0, IDLE});
      check("post_reset_irq", {31'h0, irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
